// File: rtl/dualrail_word_rx.sv
// Dual-rail spacer-separated serial word receiver with arm qualification, per-bit timeout and error pulse.
// Define DRX_PARITY_EN to expect a trailing even-parity bit after the WIDTH data bits.
module dualrail_word_rx #(
  parameter int WIDTH     = 4,
  parameter int START_CYC = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bin0,
  input  logic             bin1,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             busy,
  output logic             err
);

`ifdef DRX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int ARM_W = $clog2(START_CYC + 1);
  localparam int IDX_W = $clog2(NBITS + 1);
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_WAIT_BIT    = 2'd1;
  localparam logic [1:0] S_WAIT_SPACER = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ARM_W-1:0] arm_q, arm_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TO_W-1:0]  idle_q, idle_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             is_data;
  logic             is_spacer;
  logic             timeout_hit;
  logic [WIDTH-1:0] sh_shift;

  assign is_data     = bin0 ^ bin1;
  assign is_spacer   = bin0 & bin1;
  assign sh_shift    = (sh_q << 1) | WIDTH'(bin0);
  // Abort on the idle edge that would bring the counter up to TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (idle_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    idx_d   = idx_q;
    idle_d  = idle_q;
    sh_d    = sh_q;
    word_d  = word_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          arm_d = '0;
        end else if (arm_q == ARM_W'(START_CYC - 1)) begin
          arm_d   = '0;
          idx_d   = '0;
          sh_d    = '0;
          idle_d  = '0;
          state_d = S_WAIT_BIT;
        end else begin
          arm_d = arm_q + 1'b1;
        end
      end
      S_WAIT_BIT: begin
        if (is_data) begin
          idle_d = '0;
          if (idx_q == IDX_W'(NBITS - 1)) begin
`ifdef DRX_PARITY_EN
            if ((^sh_q ^ bin0) == 1'b0) begin
              word_d  = sh_q;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
`else
            word_d  = sh_shift;
            valid_d = 1'b1;
`endif
            arm_d   = '0;
            state_d = S_IDLE;
          end else begin
            sh_d    = sh_shift;
            idx_d   = idx_q + 1'b1;
            state_d = S_WAIT_SPACER;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          arm_d   = '0;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_WAIT_SPACER: begin
        if (is_spacer) begin
          idle_d  = '0;
          state_d = S_WAIT_BIT;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          arm_d   = '0;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      arm_q   <= '0;
      idx_q   <= '0;
      idle_q  <= '0;
      sh_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      sh_q    <= sh_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;
  assign err        = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule
